dma_cmd_seq: RTL and testbench

DMA_CMD_SEQ -- requirements
Module: dma_cmd_seq

---
 rtl/dma_cmd_seq.sv | 200 ++++++++++++++++++++
 tb/tb_dma_cmd_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_seq.sv
// dma_cmd_seq: queues DMA descriptors in a small FIFO and issues them one at a
// time to a DMA engine, waiting for a completion pulse between descriptors.
//
// Ports
//   hclk, hresetn                 clock, asynchronous active-low reset
//   i_desc_valid / o_desc_ready   descriptor push handshake (ready = FIFO not full)
//   i_desc_*                      descriptor fields to push
//   o_dma_req                     held high for 3 cycles per issued descriptor
//   o_src_addr .. o_dst_rev       fields of the descriptor being issued
//   i_dma_done                    completion pulse, honoured only while waiting
//   o_busy                        sequencer active or descriptors queued
//   o_irq / i_irq_clr             queue-drained interrupt and its clear
//   o_err / i_err_clr             sticky error (bad burst, or timeout) and its clear
//   o_level, o_done_cnt           FIFO occupancy, completed descriptor count
//
// Build option: define DMA_SEQ_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.

package dma_cmd_seq_pkg;
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] poly_deg;
        logic [14:0] addr_inc;
        logic [14:0] burst;
        logic        src_rev;
        logic        dst_rev;
    } desc_t;
endpackage

module dma_cmd_seq
    import dma_cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        i_desc_valid,
    output logic        o_desc_ready,
    input  logic [31:0] i_desc_src,
    input  logic [31:0] i_desc_dst,
    input  logic [15:0] i_desc_poly_deg,
    input  logic [14:0] i_desc_addr_inc,
    input  logic [14:0] i_desc_burst,
    input  logic        i_desc_src_rev,
    input  logic        i_desc_dst_rev,
    output logic        o_dma_req,
    output logic [31:0] o_src_addr,
    output logic [31:0] o_dst_addr,
    output logic [15:0] o_poly_deg,
    output logic [14:0] o_addr_inc,
    output logic [14:0] o_burst_size,
    output logic        o_src_rev,
    output logic        o_dst_rev,
    input  logic        i_dma_done,
    output logic        o_busy,
    output logic        o_irq,
    input  logic        i_irq_clr,
    output logic        o_err,
    input  logic        i_err_clr,
    output logic [4:0]  o_level,
    output logic [15:0] o_done_cnt
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = 5;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, REQ = 2'd2, WAIT = 2'd3} state_t;

    state_t          state_q, state_d;
    desc_t           mem [DEPTH];
    desc_t           wr_desc_c, head_c;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [1:0]      req_cnt_q, req_cnt_d;
    logic            push_c, pop_c, err_set_c, irq_set_c, done_inc_c, timeout_c;

    assign push_c    = i_desc_valid && o_desc_ready;
    assign wr_desc_c = '{src: i_desc_src, dst: i_desc_dst, poly_deg: i_desc_poly_deg,
                         addr_inc: i_desc_addr_inc, burst: i_desc_burst,
                         src_rev: i_desc_src_rev, dst_rev: i_desc_dst_rev};
    assign head_c    = mem[rd_ptr_q];
    assign o_level   = level_q;

`ifdef DMA_SEQ_TIMEOUT_EN
    // Cycles spent in the current WAIT; the last allowed cycle triggers the abort.
    logic [15:0] wait_cnt_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)              wait_cnt_q <= '0;
        else if (state_q != WAIT)  wait_cnt_q <= '0;
        else                       wait_cnt_q <= wait_cnt_q + 16'd1;
    end

    assign timeout_c = (state_q == WAIT) && (wait_cnt_q == TIMEOUT - 16'd1);
`else
    assign timeout_c = 1'b0;
`endif

    // Descriptor storage; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge hclk) begin
        if (push_c) mem[wr_ptr_q] <= wr_desc_c;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c)      level_d = level_q + LW'(1);
        else if (!push_c && pop_c) level_d = level_q - LW'(1);
    end

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= IDLE;
            req_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
        end
    end

    // Next state and per-cycle events. A push into an empty FIFO starts LOAD
    // immediately so the first request follows the push by two cycles.
    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        pop_c      = 1'b0;
        err_set_c  = 1'b0;
        irq_set_c  = 1'b0;
        done_inc_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0 || push_c) state_d = LOAD;
            end
            LOAD: begin
                pop_c = 1'b1;
                if (head_c.burst[14:4] != '0) begin
                    state_d   = REQ;
                    req_cnt_d = '0;
                end else begin
                    state_d   = IDLE;
                    err_set_c = 1'b1;
                end
            end
            REQ: begin
                if (req_cnt_q == 2'd2) state_d = WAIT;
                else                   req_cnt_d = req_cnt_q + 2'd1;
            end
            WAIT: begin
                if (i_dma_done) begin
                    state_d    = IDLE;
                    done_inc_c = 1'b1;
                    irq_set_c  = (level_q == '0) && !push_c;
                end else if (timeout_c) begin
                    state_d   = IDLE;
                    err_set_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; fields latch on the pop and hold until the next one.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            o_desc_ready <= 1'b1;
            o_dma_req    <= 1'b0;
            o_busy       <= 1'b0;
            o_irq        <= 1'b0;
            o_err        <= 1'b0;
            o_done_cnt   <= '0;
            {o_src_addr, o_dst_addr, o_poly_deg, o_addr_inc,
             o_burst_size, o_src_rev, o_dst_rev} <= '0;
        end else begin
            o_desc_ready <= (level_d != LW'(DEPTH));
            o_dma_req    <= (state_d == REQ);
            o_busy       <= (state_d != IDLE) || (level_d != '0);
            if (irq_set_c)      o_irq <= 1'b1;
            else if (i_irq_clr) o_irq <= 1'b0;
            if (err_set_c)      o_err <= 1'b1;
            else if (i_err_clr) o_err <= 1'b0;
            if (done_inc_c)     o_done_cnt <= o_done_cnt + 16'd1;
            if (pop_c) begin
                {o_src_addr, o_dst_addr, o_poly_deg, o_addr_inc,
                 o_burst_size, o_src_rev, o_dst_rev} <= head_c;
            end
        end
    end
endmodule

// File: tb/tb_dma_cmd_seq.sv
module tb_dma_cmd_seq;
    import dma_cmd_seq_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        i_desc_valid = 1'b0;
    logic        o_desc_ready;
    logic [31:0] i_desc_src = '0;
    logic [31:0] i_desc_dst = '0;
    logic [15:0] i_desc_poly_deg = '0;
    logic [14:0] i_desc_addr_inc = '0;
    logic [14:0] i_desc_burst = '0;
    logic        i_desc_src_rev = 1'b0;
    logic        i_desc_dst_rev = 1'b0;
    logic        o_dma_req;
    logic [31:0] o_src_addr, o_dst_addr;
    logic [15:0] o_poly_deg;
    logic [14:0] o_addr_inc, o_burst_size;
    logic        o_src_rev, o_dst_rev;
    logic        i_dma_done = 1'b0;
    logic        o_busy, o_irq, o_err;
    logic        i_irq_clr = 1'b0;
    logic        i_err_clr = 1'b0;
    logic [4:0]  o_level;
    logic [15:0] o_done_cnt;

    int checks = 0;
    int failures = 0;
    int exp_done = 0;

    dma_cmd_seq #(.DEPTH(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
        .i_desc_src(i_desc_src), .i_desc_dst(i_desc_dst),
        .i_desc_poly_deg(i_desc_poly_deg), .i_desc_addr_inc(i_desc_addr_inc),
        .i_desc_burst(i_desc_burst), .i_desc_src_rev(i_desc_src_rev),
        .i_desc_dst_rev(i_desc_dst_rev),
        .o_dma_req(o_dma_req), .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr),
        .o_poly_deg(o_poly_deg), .o_addr_inc(o_addr_inc), .o_burst_size(o_burst_size),
        .o_src_rev(o_src_rev), .o_dst_rev(o_dst_rev),
        .i_dma_done(i_dma_done), .o_busy(o_busy),
        .o_irq(o_irq), .i_irq_clr(i_irq_clr),
        .o_err(o_err), .i_err_clr(i_err_clr),
        .o_level(o_level), .o_done_cnt(o_done_cnt)
    );

    always #5 hclk = ~hclk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    function automatic desc_t mk(input logic [31:0] s, input logic [31:0] d, input logic [14:0] b);
        desc_t r;
        r.src      = s;
        r.dst      = d;
        r.poly_deg = s[15:0] ^ 16'h5A5A;
        r.addr_inc = d[14:0] ^ 15'h0004;
        r.burst    = b;
        r.src_rev  = s[12];
        r.dst_rev  = d[13];
        return r;
    endfunction

    function automatic desc_t fields();
        return {o_src_addr, o_dst_addr, o_poly_deg, o_addr_inc, o_burst_size, o_src_rev, o_dst_rev};
    endfunction

    task automatic drive_desc(input desc_t d);
        i_desc_src      = d.src;
        i_desc_dst      = d.dst;
        i_desc_poly_deg = d.poly_deg;
        i_desc_addr_inc = d.addr_inc;
        i_desc_burst    = d.burst;
        i_desc_src_rev  = d.src_rev;
        i_desc_dst_rev  = d.dst_rev;
    endtask

    // Push one descriptor while the FIFO has room; returns in the cycle after the push.
    task automatic push_one(input desc_t d);
        drive_desc(d);
        i_desc_valid = 1'b1;
        tick();
        i_desc_valid = 1'b0;
    endtask

    task automatic pulse_done();
        i_dma_done = 1'b1;
        tick();
        i_dma_done = 1'b0;
    endtask

    // Advance until o_dma_req is seen high, at most 40 cycles.
    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_dma_req) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_desc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", o_desc_ready); end
        checks++; if ({o_dma_req, o_busy, o_irq, o_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b want 0000", {o_dma_req, o_busy, o_irq, o_err}); end
        checks++; if (o_level !== 5'd0 || o_done_cnt !== 16'd0) begin failures++; $display("FAIL reset_counts level %0d done %0d want 0 0", o_level, o_done_cnt); end
        checks++; if (fields() !== desc_t'(0)) begin failures++; $display("FAIL reset_fields got %h want 0", fields()); end
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        desc_t d = mk(32'h0000_1000, 32'h0000_2000, 15'h0040);
        push_one(d);
        // LOAD cycle: descriptor already in FIFO, no request yet
        checks++; if (o_dma_req !== 1'b0 || o_level !== 5'd1) begin failures++; $display("FAIL single_load req %b level %0d want 0 1", o_dma_req, o_level); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_dma_req !== 1'b1) begin failures++; $display("FAIL single_req_cycle%0d got %b want 1", k, o_dma_req); end
            checks++; if (fields() !== d) begin failures++; $display("FAIL single_fields got %h want %h", fields(), d); end
        end
        tick();
        checks++; if (o_dma_req !== 1'b0) begin failures++; $display("FAIL single_req_end got %b want 0", o_dma_req); end
        repeat (5) tick();
        checks++; if ({o_busy, o_dma_req, o_irq} !== 3'b100) begin failures++; $display("FAIL single_wait busy/req/irq %b want 100", {o_busy, o_dma_req, o_irq}); end
        checks++; if (fields() !== d) begin failures++; $display("FAIL single_fields_hold got %h want %h", fields(), d); end
        pulse_done();
        exp_done++;
        checks++; if (o_irq !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL single_done irq %b busy %b want 1 0", o_irq, o_busy); end
        checks++; if (o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL single_done_cnt got %0d want %0d", o_done_cnt, exp_done); end
    endtask

    task automatic test_idle_done_irq_clr();
        desc_t d = mk(32'h0000_3000, 32'h0000_4000, 15'h0100);
        bit seen;
        pulse_done();
        tick();
        checks++; if (o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL idle_done_cnt got %0d want %0d", o_done_cnt, exp_done); end
        checks++; if ({o_busy, o_dma_req, o_irq} !== 3'b001) begin failures++; $display("FAIL idle_done_state busy/req/irq %b want 001", {o_busy, o_dma_req, o_irq}); end
        push_one(d);
        wait_req(seen);
        checks++; if (!seen) begin failures++; $display("FAIL irqclr_req_timeout got no req want req"); end
        repeat (3) tick();
        i_irq_clr = 1'b1;
        pulse_done();
        i_irq_clr = 1'b0;
        exp_done++;
        checks++; if (o_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got %b want 1", o_irq); end
        checks++; if (o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL irqclr_done_cnt got %0d want %0d", o_done_cnt, exp_done); end
        i_irq_clr = 1'b1;
        tick();
        i_irq_clr = 1'b0;
        checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got %b want 0", o_irq); end
    endtask

    task automatic test_bad_burst();
        desc_t bad  = mk(32'h0000_5000, 32'h0000_6000, 15'h000F);
        desc_t good = mk(32'h0000_7000, 32'h0000_8000, 15'h0010);
        bit seen;
        bit req_seen = 1'b0;
        push_one(bad);
        tick();
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL bad_err got %b want 1", o_err); end
        for (int k = 0; k < 4; k++) begin
            if (o_dma_req) req_seen = 1'b1;
            tick();
        end
        checks++; if (req_seen || o_busy !== 1'b0 || o_irq !== 1'b0) begin failures++; $display("FAIL bad_no_req req %b busy %b irq %b want 0 0 0", req_seen, o_busy, o_irq); end
        i_err_clr = 1'b1;
        tick();
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", o_err); end
        // clear held across a second bad descriptor: the set must win
        push_one(bad);
        tick();
        i_err_clr = 1'b0;
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_set_wins got %b want 1", o_err); end
        push_one(good);
        wait_req(seen);
        checks++; if (!seen) begin failures++; $display("FAIL bad_next_req_timeout got no req want req"); end
        checks++; if (fields() !== good) begin failures++; $display("FAIL bad_next_fields got %h want %h", fields(), good); end
        repeat (3) tick();
        pulse_done();
        exp_done++;
        checks++; if (o_done_cnt !== 16'(exp_done) || o_err !== 1'b1) begin failures++; $display("FAIL bad_next_done cnt %0d err %b want %0d 1", o_done_cnt, o_err, exp_done); end
        i_err_clr = 1'b1;
        i_irq_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        i_irq_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        desc_t q [5];
        int idx = 0;
        int guard = 0;
        bit acc;
        bit seen;
        for (int i = 0; i < 5; i++) q[i] = mk(32'hA000_0000 + 32'(i * 16'h100), 32'hB000_0000 + 32'(i * 8), 15'h0020 + 15'(i));
        while (idx < 5 && guard < 50) begin
            drive_desc(q[idx]);
            i_desc_valid = 1'b1;
            acc = o_desc_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        i_desc_valid = 1'b0;
        checks++; if (idx != 5 || guard != 5) begin failures++; $display("FAIL b2b_accept pushed %0d in %0d cycles want 5 in 5", idx, guard); end
        checks++; if (o_desc_ready !== 1'b0 || o_level !== 5'd4) begin failures++; $display("FAIL b2b_full ready %b level %0d want 0 4", o_desc_ready, o_level); end
        checks++; if (fields() !== q[0] || o_dma_req !== 1'b0) begin failures++; $display("FAIL b2b_first fields %h req %b want %h 0", fields(), o_dma_req, q[0]); end
        pulse_done();
        exp_done++;
        checks++; if (o_irq !== 1'b0 || o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL b2b_done0 irq %b cnt %0d want 0 %0d", o_irq, o_done_cnt, exp_done); end
        for (int j = 1; j < 5; j++) begin
            wait_req(seen);
            checks++; if (!seen || fields() !== q[j]) begin failures++; $display("FAIL b2b_issue%0d seen %b fields %h want 1 %h", j, seen, fields(), q[j]); end
            repeat (3) tick();
            checks++; if (o_dma_req !== 1'b0) begin failures++; $display("FAIL b2b_wait%0d req %b want 0", j, o_dma_req); end
            pulse_done();
            exp_done++;
            checks++; if (o_irq !== (j == 4) || o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL b2b_done%0d irq %b cnt %0d want %b %0d", j, o_irq, o_done_cnt, (j == 4), exp_done); end
        end
        checks++; if (o_level !== 5'd0 || o_desc_ready !== 1'b1) begin failures++; $display("FAIL b2b_drained level %0d ready %b want 0 1", o_level, o_desc_ready); end
    endtask

    task automatic test_reset_mid();
        desc_t d = mk(32'h0000_C000, 32'h0000_D000, 15'h0080);
        bit seen;
        bit req_seen = 1'b0;
        push_one(d);
        wait_req(seen);
        tick();
        // asynchronous reset in the middle of the REQ window
        #2 hresetn = 1'b0;
        #1;
        checks++; if (!seen || o_dma_req !== 1'b0) begin failures++; $display("FAIL rst_req_drop seen %b req %b want 1 0", seen, o_dma_req); end
        @(negedge hclk);
        hresetn = 1'b1;
        exp_done = 0;
        tick();
        push_one(d);
        wait_req(seen);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) push_one(mk(32'h0000_E000 + 32'(i), 32'h0000_F000, 15'h0030));
        checks++; if (!seen || o_level !== 5'd3 || o_dma_req !== 1'b0) begin failures++; $display("FAIL rst_setup seen %b level %0d req %b want 1 3 0", seen, o_level, o_dma_req); end
        #2 hresetn = 1'b0;
        #1;
        checks++; if (o_level !== 5'd0 || o_dma_req !== 1'b0 || o_desc_ready !== 1'b1) begin failures++; $display("FAIL rst_wait level %0d req %b ready %b want 0 0 1", o_level, o_dma_req, o_desc_ready); end
        checks++; if ({o_busy, o_irq, o_err} !== 3'b000 || o_done_cnt !== 16'(exp_done)) begin failures++; $display("FAIL rst_wait_flags %b cnt %0d want 000 0", {o_busy, o_irq, o_err}, o_done_cnt); end
        @(negedge hclk);
        hresetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_dma_req) req_seen = 1'b1;
        end
        checks++; if (req_seen || o_busy !== 1'b0 || o_level !== 5'd0) begin failures++; $display("FAIL rst_no_issue req %b busy %b level %0d want 0 0 0", req_seen, o_busy, o_level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_idle_done_irq_clr();
        test_bad_burst();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
